// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between NUM_REQ streams.
// Grants last up to MAX_BURST accepted beats; new grants wait while the fifo is full.
module fifo_wr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int FIFO_DEPTH = 2,
  parameter  int MAX_BURST  = 4,
  localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int FILL_W     = $clog2(FIFO_DEPTH + 1),
  localparam int CNT_W      = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_vld,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_rdy,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_vld,
  input  logic                          out_rdy,
  input  logic [FILL_W-1:0]             fill_level,
  output logic                          grant_vld,
  output logic [IDX_W-1:0]              grant_idx
);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_found;
  logic               xfer;

  // Rotating search starting just after the previous owner.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!sel_found && req_vld[IDX_W'((int'(last_grant_q) + k) % NUM_REQ)]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      end
    end
  end

  // Zero-latency routing; reset gates everything so no beat moves in a reset cycle.
  always_comb begin
    out_vld  = 1'b0;
    req_rdy  = '0;
    out_data = req_data[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
    if (rst_n && (state_q == GRANT)) begin
      out_vld               = req_vld[grant_idx_q];
      req_rdy[grant_idx_q]  = out_rdy;
    end
  end

  assign xfer      = out_vld && out_rdy;
  assign grant_vld = rst_n && (state_q == GRANT);
  assign grant_idx = grant_idx_q;

  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel_found && (fill_level != FILL_W'(FIFO_DEPTH))) begin
          grant_idx_d = sel_idx;
          beat_cnt_d  = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (!req_vld[grant_idx_q]) begin
          state_d      = IDLE;
          last_grant_d = grant_idx_q;
          beat_cnt_d   = '0;
        end else if (xfer) begin
          if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d      = IDLE;
            last_grant_d = grant_idx_q;
            beat_cnt_d   = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked cycle by cycle against a grant-level model.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int FD = 2;
  localparam int MB = 4;
  localparam int IW = 2;
  localparam int FW = $clog2(FD + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_vld;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_rdy;
  logic [DW-1:0]     out_data;
  logic              out_vld;
  logic              out_rdy;
  logic [FW-1:0]     fill_level;
  logic              grant_vld;
  logic [IW-1:0]     grant_idx;

  int n_vec = 0;
  int n_bad = 0;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .fill_level(fill_level),
    .grant_vld(grant_vld), .grant_idx(grant_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who owns the port (-1 = nobody), who owned it last, beats accepted so far.
  int m_owner = -1;
  int m_last  = NR - 1;
  int m_beats = 0;

  function automatic int pick(input int last, input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++)
      if (v[IW'((last + k) % NR)]) return (last + k) % NR;
    return -1;
  endfunction

  initial begin : compare
    logic          e_gv, e_ov;
    logic [NR-1:0] e_rdy;
    logic [DW-1:0] e_data;
    logic [IW-1:0] oi;
    forever begin
      @(negedge clk);
      e_gv = 1'b0; e_ov = 1'b0; e_rdy = '0; e_data = '0; oi = '0;
      if (rst_n && m_owner >= 0) begin
        oi     = IW'(m_owner);
        e_gv   = 1'b1;
        e_ov   = req_vld[oi];
        e_rdy  = out_rdy ? NR'(1 << m_owner) : '0;
        e_data = req_data[m_owner*DW +: DW];
      end
      check("m_grant_vld", 32'(grant_vld), 32'(e_gv));
      check("m_out_vld", 32'(out_vld), 32'(e_ov));
      check("m_req_rdy", 32'(req_rdy), 32'(e_rdy));
      if (e_gv) check("m_grant_idx", 32'(grant_idx), 32'(oi));
      if (e_ov) check("m_out_data", 32'(out_data), 32'(e_data));
      if (!rst_n) begin
        m_owner = -1; m_last = NR - 1; m_beats = 0;
      end else if (m_owner < 0) begin
        if (req_vld != '0 && int'(fill_level) != FD) begin
          m_owner = pick(m_last, req_vld);
          m_beats = 0;
        end
      end else if (!req_vld[oi]) begin
        m_last = m_owner; m_owner = -1;
      end else if (out_rdy) begin
        m_beats++;
        if (m_beats == MB) begin m_last = m_owner; m_owner = -1; end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_vld = '0; out_rdy = 1'b1; fill_level = '0;
    @(negedge clk);
    check("rst_grant_vld", 32'(grant_vld), 32'd0);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_req_rdy", 32'(req_rdy), 32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin : stim
    logic [6:0]    trace;
    logic [NR-1:0] seen;
    logic [NR-1:0] vtab [6];
    int            order [$];
    int            nx, bad1h;
    logic          prev;
    logic [4:0]    exp_order [5];

    req_data = '0;
    do_reset();

    // Single requester 0: burst of 4, one idle bubble, re-grant.
    req_vld = 4'b0001; req_data[0 +: DW] = 8'h11; out_rdy = 1'b1; fill_level = '0;
    trace = '0; nx = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      trace[c] = grant_vld;
      if (out_vld && out_rdy) nx++;
      if (c == 6) check("A_regrant_idx", 32'(grant_idx), 32'd0);
      tick();
    end
    check("A_gv_trace", 32'(trace), 32'b1011110);
    check("A_beats", 32'(nx), 32'd5);

    // All four requesting: strict rotation 0,1,2,3,0.
    do_reset();
    req_vld = 4'b1111; req_data = 32'h44332211;
    order.delete(); nx = 0; bad1h = 0; prev = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (grant_vld && !prev) order.push_back(int'(grant_idx));
      prev = grant_vld;
      if (!$onehot0(req_rdy)) bad1h++;
      if (out_vld && out_rdy) nx++;
      tick();
    end
    exp_order = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd0};
    check("B_num_grants", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      check("B_grant_order", 32'(order[i]), 32'(exp_order[i]));
    check("B_beats", 32'(nx), 32'd20);
    check("B_onehot_viol", 32'(bad1h), 32'd0);

    // Requester 2 sends two beats then drops; next grant prefers 3 over 0.
    do_reset();
    vtab = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1001, 4'b1001};
    req_data = 32'h77665544; nx = 0;
    for (int c = 0; c < 6; c++) begin
      req_vld = vtab[c];
      @(negedge clk);
      if (req_rdy[2] && req_vld[2]) nx++;
      if (c == 4) check("C_idle_gv", 32'(grant_vld), 32'd0);
      if (c == 5) begin
        check("C_gv", 32'(grant_vld), 32'd1);
        check("C_idx", 32'(grant_idx), 32'd3);
      end
      tick();
    end
    check("C_beats", 32'(nx), 32'd2);

    // Stall mid-burst on requester 1 for five cycles.
    do_reset();
    req_vld = 4'b0010; req_data = '0; req_data[DW +: DW] = 8'hA5; nx = 0;
    for (int c = 0; c < 11; c++) begin
      out_rdy = !(c >= 2 && c <= 6);
      @(negedge clk);
      if (out_vld && out_rdy) nx++;
      if (c >= 2 && c <= 6) begin
        check("D_stall_vld", 32'(out_vld), 32'd1);
        check("D_stall_data", 32'(out_data), 32'hA5);
      end
      if (c == 9)  check("D_last_gv", 32'(grant_vld), 32'd1);
      if (c == 10) check("D_release", 32'(grant_vld), 32'd0);
      tick();
    end
    check("D_beats", 32'(nx), 32'd4);

    // Full fifo blocks new grants until fill_level drops.
    do_reset();
    req_vld = 4'b0100; out_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      fill_level = (c < 3) ? FW'(2) : FW'(1);
      @(negedge clk);
      if (c < 4) check("E_blocked_gv", 32'(grant_vld), 32'd0);
      if (c == 4) begin
        check("E_gv", 32'(grant_vld), 32'd1);
        check("E_idx", 32'(grant_idx), 32'd2);
      end
      tick();
    end

    // Reset mid-burst on requester 3; arbitration restarts at requester 0.
    do_reset();
    req_vld = 4'b1000; out_rdy = 1'b1; fill_level = '0;
    for (int c = 0; c < 5; c++) begin
      rst_n = (c != 2);
      if (c >= 2) req_vld = 4'b1001;
      @(negedge clk);
      if (c == 1) check("F_idx3", 32'(grant_idx), 32'd3);
      if (c == 2) begin
        check("F_rst_gv", 32'(grant_vld), 32'd0);
        check("F_rst_ov", 32'(out_vld), 32'd0);
        check("F_rst_rdy", 32'(req_rdy), 32'd0);
      end
      if (c == 4) begin
        check("F_gv", 32'(grant_vld), 32'd1);
        check("F_idx0", 32'(grant_idx), 32'd0);
      end
      tick();
    end
    rst_n = 1'b1;

    // Randomized traffic; requesters hold data until accepted.
    do_reset();
    seen = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_vld[IW'(i)] || seen[IW'(i)]) begin
          req_vld[IW'(i)]      = ($urandom_range(0, 2) != 0);
          req_data[i*DW +: DW] = DW'($urandom);
        end
      end
      out_rdy    = ($urandom_range(0, 3) != 0);
      fill_level = FW'($urandom_range(0, FD));
      rst_n      = ($urandom_range(0, 99) != 0);
      @(negedge clk);
      seen = req_rdy & req_vld;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
